// File: rtl/rib_wait_bridge.sv
// Wait-state bridge: latches a single-cycle core bus access and stalls the core until a req/ack slave answers.
// Optional stuck-access abort is built only when RIB_WAIT_TIMEOUT_EN is defined.
module rib_wait_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8,
   parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m_addr_i,
   input  logic [31:0] m_data_i,
   input  logic        m_req_i,
   input  logic        m_we_i,
   output logic [31:0] m_data_o,
   output logic        hold_o,
   output logic [31:0] s_addr_o,
   output logic [31:0] s_data_o,
   output logic        s_req_o,
   output logic        s_we_o,
   input  logic [31:0] s_data_i,
   input  logic        s_ack_i,
   output logic        err_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] rdata;

`ifdef RIB_WAIT_TIMEOUT_EN
   // Counter holds the number of REQ cycles already completed; abort fires in the last allowed one.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;
   logic             err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         s_addr_o <= '0;
         s_data_o <= '0;
         s_we_o   <= 1'b0;
         rdata    <= '0;
         cnt      <= '0;
         err      <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (m_req_i) begin
                  s_addr_o <= m_addr_i;
                  s_data_o <= m_data_i;
                  s_we_o   <= m_we_i;
                  state    <= REQ;
               end
            end
            REQ: begin
               // Ack has priority over a coinciding timeout.
               if (s_ack_i) begin
                  rdata <= s_we_o ? '0 : s_data_i;
                  cnt   <= '0;
                  state <= DONE;
               end else if (cnt == CNT_LAST) begin
                  rdata <= ERR_DATA;
                  err   <= 1'b1;
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign err_o = err;
`else
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         s_addr_o <= '0;
         s_data_o <= '0;
         s_we_o   <= 1'b0;
         rdata    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (m_req_i) begin
                  s_addr_o <= m_addr_i;
                  s_data_o <= m_data_i;
                  s_we_o   <= m_we_i;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (s_ack_i) begin
                  rdata <= s_we_o ? '0 : s_data_i;
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign err_o = 1'b0;
`endif

   // Hold must rise in the request cycle itself, before the state register can react.
   assign hold_o   = (state == REQ) || ((state == IDLE) && m_req_i);
   assign s_req_o  = (state == REQ);
   assign m_data_o = rdata;

endmodule

// File: doc/rib_wait_bridge.md
# rib_wait_bridge

Wait-state bridge between the core's single-cycle data-bus master port (`rib_ex_*`) and a slow peripheral slave with a req/ack handshake. It latches each core access, holds the pipeline until the slave acknowledges, then returns read data. With the configured option it aborts a stuck access after a cycle budget. It sits directly downstream of the core's data port, and its `hold_o` is OR-ed into the bus hold flag that feeds the core.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles spent in REQ before abort; range 1..2^CNT_W-1.
- `CNT_W`, 8: width of the wait counter.
- `ERR_DATA`, 32'hDEADBEEF: read data returned on timeout.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `m_addr_i`  in  32  core access address.
- `m_data_i`  in  32  core write data.
- `m_req_i`  in  1  core access request.
- `m_we_i`  in  1  core write enable.
- `m_data_o`  out  32  read data returned to core.
- `hold_o`  out  1  pipeline hold request to core.
- `s_addr_o`  out  32  latched slave address.
- `s_data_o`  out  32  latched slave write data.
- `s_req_o`  out  1  slave request, level, held until ack.
- `s_we_o`  out  1  latched slave write enable.
- `s_data_i`  in  32  slave read data, valid with ack.
- `s_ack_i`  in  1  slave acknowledge, single-cycle pulse.
- `err_o`  out  1  one-cycle pulse on timeout abort.

## Operation
- FSM has three states: IDLE, REQ, DONE. Encoding is 2-bit, and the reset state is IDLE.
- IDLE:
  - `m_req_i`=1 latches addr, wdata and we into the `s_*` registers and moves to REQ.
  - `hold_o` is asserted combinationally in this same cycle.
  - `s_ack_i` is ignored in IDLE.
- REQ:
  - `s_req_o`=1 and `hold_o`=1.
  - The wait counter increments every cycle.
  - `s_ack_i`=1 captures `s_data_i` into the read register (0 on writes) and moves to DONE.
- DONE:
  - `hold_o`=0 and `m_data_o` = read register, so the core completes the instruction this cycle.
  - `s_req_o`=0, and `m_req_i` is ignored; it is still the same access.
  - The FSM returns to IDLE unconditionally on the next cycle.
- `m_data_o` holds the last captured value in every state. The counter clears on leaving REQ.
- The `s_addr_o`, `s_data_o` and `s_we_o` registers are stable from the REQ entry until the next IDLE capture.
- Back-to-back accesses:
  - A new `m_req_i` is sampled in the IDLE cycle after DONE.
  - No access is lost or duplicated.
- The core guarantees that `m_*` inputs stay stable while `hold_o`=1. The bridge uses only the latched copies.

## Timing
- Reset values of outputs:
  - `hold_o`=0 (IDLE with `m_req_i`=0), `s_req_o`=0, `s_we_o`=0, `err_o`=0.
  - `s_addr_o`, `s_data_o` and `m_data_o` reset to 0.
- Latency: request in cycle 0 (IDLE), `s_req_o` high from cycle 1.
  - An ack in cycle k (k≥1) gives DONE in cycle k+1, with `hold_o` low in cycle k+1.
  - The minimum stall is 2 cycles (`hold_o` high in cycles 0 and 1).
- Ack and timeout in the same cycle: ack wins, normal completion, no `err_o`.
- `rst` low mid-access:
  - All state returns to IDLE asynchronously and `s_req_o` drops immediately.
  - A late `s_ack_i` after reset release lands in IDLE and is ignored.
- A spurious `s_ack_i` in IDLE or DONE has no effect.

## Configuration
- Macro `RIB_WAIT_TIMEOUT_EN` defined:
  - When the REQ counter reaches `TIMEOUT_CYCLES` without ack, the FSM goes to DONE.
  - The read register takes `ERR_DATA`.
  - `err_o` pulses high for exactly the DONE cycle.
  - `s_req_o` drops in DONE.
- Macro not defined:
  - No counter logic is built, and the bridge waits indefinitely in REQ.
  - `err_o` is tied to 0.

## Test plan
- Read, ack in cycle 3:
  - Stimulus: `m_req_i`=1, `m_we_i`=0, addr 0x1000_0004; `s_data_i`=0x1234_5678 with ack.
  - Required: `hold_o` high in cycles 0–3 and low in cycle 4; `m_data_o`=0x1234_5678 in cycle 4; `s_req_o` high in cycles 1–3.
- Write, ack in cycle 1:
  - Stimulus: wdata 0xA5A5_A5A5 to 0x3000_0000.
  - Required: `s_we_o`=1, `s_data_o`=0xA5A5_A5A5 in cycle 1; `hold_o` low in cycle 2; exactly one `s_req_o` assertion.
- Two back-to-back reads, each acked in cycle 1:
  - Required: two separate slave requests, 5 total cycles from first req to second DONE, no duplicate requests.
- Async reset mid-REQ:
  - Stimulus: `rst` low in cycle 2 while waiting, then ack in cycle 4 after release.
  - Required: `s_req_o`=0 and `hold_o`=0 immediately; the ack is ignored; FSM in IDLE.
- With `RIB_WAIT_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, no ack:
  - Required: DONE entered after 4 REQ cycles; `m_data_o`=0xDEADBEEF and `err_o`=1 for one cycle.
  - Variant: ack coincident with the 4th REQ cycle returns slave data and `err_o`=0.
- Without the macro, no ack for 1000 cycles:
  - Required: `hold_o` and `s_req_o` remain 1 and `err_o` stays 0.
  - A later ack completes the access normally.
